// File: rtl/jtframe_sdram_rdctrl.sv
// Read-only SDRAM controller: power-up init, periodic auto-refresh, and
// ACTIVE + READ-with-auto-precharge bursts of two 16-bit beats per request.
module jtframe_sdram_rdctrl #(
  parameter int SDRAMW    = 22,
  parameter int CL        = 2,
  parameter int TRCD      = 2,
  parameter int TRP       = 2,
  parameter int TRFC      = 7,
  parameter int REFCNT    = 370,
  parameter int INIT_WAIT = 4800
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              req,
  input  logic [SDRAMW-1:0] addr,
  output logic              ack,
  output logic              data_rdy,
  output logic [31:0]       data_read,
  input  logic [15:0]       sdram_dq,
  output logic [12:0]       sdram_a,
  output logic [1:0]        sdram_ba,
  output logic [1:0]        sdram_dqm,
  output logic              sdram_ncs,
  output logic              sdram_nras,
  output logic              sdram_ncas,
  output logic              sdram_nwe
);

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_ACT     = 4'b0011;
  localparam logic [3:0] CMD_READ    = 4'b0101;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_REF     = 4'b0001;
  localparam logic [3:0] CMD_MRS     = 4'b0000;

  localparam logic [2:0]  CL_BITS = 3'(CL);
  localparam logic [12:0] MRS_VAL = {3'b000, 1'b1, 2'b00, CL_BITS, 1'b0, 3'b001};

  // Last READ-state count before IDLE: never before data_rdy, and at least
  // TRP cycles after the final beat so the auto-precharge has completed.
  localparam int RD_END = (TRP > 2) ? CL + TRP - 1 : CL + 1;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_REF,
    S_INIT_MRS,
    S_IDLE,
    S_REFRESH,
    S_ACTIVE,
    S_READ
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] refcnt;
  logic        ref_pending;
  logic        init_done;
  logic        second_ref;
  logic [8:0]  col;
  logic [15:0] beat0;
  logic [15:0] beat1;
  logic [3:0]  cmd;

  assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd;
  assign sdram_ba = 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data holding registers are reset too; they are few and it
      // keeps data_read deterministic after an aborted access.
      state       <= S_INIT_WAIT;
      cnt         <= '0;
      refcnt      <= 16'(REFCNT);
      ref_pending <= 1'b0;
      init_done   <= 1'b0;
      second_ref  <= 1'b0;
      col         <= '0;
      beat0       <= '0;
      beat1       <= '0;
      cmd         <= CMD_INHIBIT;
      sdram_a     <= '0;
      sdram_dqm   <= 2'b11;
      ack         <= 1'b0;
      data_rdy    <= 1'b0;
      data_read   <= '0;
    end else begin
      ack      <= 1'b0;
      data_rdy <= 1'b0;
      cmd      <= CMD_NOP;

      case (state)
        S_INIT_WAIT: begin
          if (cnt == 16'(INIT_WAIT)) begin
            cmd     <= CMD_PRE;
            sdram_a <= 13'h0400;
            cnt     <= '0;
            state   <= S_INIT_PRE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_INIT_PRE: begin
          if (cnt == 16'(TRP)) begin
            cmd        <= CMD_REF;
            cnt        <= '0;
            second_ref <= 1'b0;
            state      <= S_INIT_REF;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_INIT_REF: begin
          if (cnt == 16'(TRFC - 1)) begin
            cnt <= '0;
            if (!second_ref) begin
              cmd        <= CMD_REF;
              second_ref <= 1'b1;
            end else begin
              cmd     <= CMD_MRS;
              sdram_a <= MRS_VAL;
              state   <= S_INIT_MRS;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_INIT_MRS: begin
          if (cnt == 16'd1) begin
            sdram_dqm <= 2'b00;
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_IDLE: begin
          if (ref_pending) begin
            cmd         <= CMD_REF;
            ref_pending <= 1'b0;
            cnt         <= '0;
            state       <= S_REFRESH;
          end else if (req) begin
            cmd     <= CMD_ACT;
            sdram_a <= 13'(addr[SDRAMW-1:9]);
            col     <= addr[8:0] & 9'h1FE;
            ack     <= 1'b1;
            cnt     <= '0;
            state   <= S_ACTIVE;
          end
        end

        S_REFRESH: begin
          if (cnt == 16'(TRFC - 2)) state <= S_IDLE;
          else                      cnt   <= cnt + 16'd1;
        end

        S_ACTIVE: begin
          if (cnt == 16'(TRCD - 1)) begin
            cmd     <= CMD_READ;
            sdram_a <= {4'b0010, col};
            cnt     <= '0;
            state   <= S_READ;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_READ: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'(CL - 1)) beat0 <= sdram_dq;
          if (cnt == 16'(CL))     beat1 <= sdram_dq;
          if (cnt == 16'(CL + 1)) begin
            data_read <= {beat1, beat0};
            data_rdy  <= 1'b1;
          end
          if (cnt == 16'(RD_END)) state <= S_IDLE;
        end

        default: state <= S_INIT_WAIT;
      endcase

      // NOTE: the timer sits after the FSM so that an expiry in the same cycle
      // a REF is issued wins over the clear (last non-blocking write wins).
      if (init_done) begin
        if (refcnt == 16'd1) begin
          refcnt      <= 16'(REFCNT);
          ref_pending <= 1'b1;
        end else begin
          refcnt <= refcnt - 16'd1;
        end
      end
    end
  end

endmodule
